// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, stalling the
// pipeline until a registered result is ready.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall_req
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  // hi: partial product high word / partial remainder
  // lo: multiplier being consumed / dividend shifting into quotient
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             done_q, done_d;

  logic             sgn_a, sgn_b, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN:0]    mul_sum, div_trial;
  logic             div_ge;
  logic [XLEN-1:0]  step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]  fin;

  // Operand decode for the instruction waiting in IDLE.
  always_comb begin
    sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    mag_a    = (sgn_a && opA[XLEN-1]) ? (~opA + 1'b1) : opA;
    mag_b    = (sgn_b && opB[XLEN-1]) ? (~opB + 1'b1) : opB;
    is_div   = funct3[2];
    div_zero = is_div && (opB == '0);
    div_ovf  = is_div && !funct3[0] && (opA == MinNeg) && (opB == AllOnes);
  end

  // One iteration of the shared datapath plus the sign-corrected final result.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_trial >= {1'b0, b_q};
    if (f3_q[2]) begin
      step_hi = div_ge ? XLEN'(div_trial - {1'b0, b_q}) : div_trial[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {step_hi, step_lo};
    prod_s = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
    if (f3_q[2]) begin
      if (f3_q[1]) fin = sa_q ? (~step_hi + 1'b1) : step_hi;
      else         fin = (sa_q ^ sb_q) ? (~step_lo + 1'b1) : step_lo;
    end else if (f3_q == 3'b000) begin
      fin = prod_s[XLEN-1:0];
    end else begin
      fin = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush overrides everything and leaves result untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // done_q blocks the still-high start of the instruction just retired
        if (start && !done_q) begin
          f3_d  = funct3;
          sa_d  = sgn_a && opA[XLEN-1];
          sb_d  = sgn_b && opB[XLEN-1];
          hi_d  = '0;
          lo_d  = mag_a;
          b_d   = mag_b;
          cnt_d = '0;
          if (div_zero) begin
            result_d = funct3[1] ? opA : AllOnes;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : MinNeg;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = fin;
          state_d  = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Outputs; stall drops in the done cycle so the pipeline advances once.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    result    = result_q;
    stall_req = start & ~done_q & ~flush;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic        busy, done, stall_req;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .funct3    (funct3),
    .opA       (opA),
    .opB       (opB),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub, ps;
    logic [63:0] pu;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'b000: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'b001: begin ps = sa * sb; return ps[63:32]; end
      3'b010: begin ps = sa * ub; return ps[63:32]; end
      3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one instruction (start held as a stalled pipeline would) and check it.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    int          lat, exp_lat, stall_bad;
    logic        seen;
    exp       = ref_model(f3, a, b);
    exp_lat   = ref_latency(f3, a, b);
    funct3    = f3;
    opA       = a;
    opB       = b;
    start     = 1'b1;
    #1;
    check_eq({tag, "_stall0"}, stall_req, 1'b1);
    @(posedge clk); #1;
    check_eq({tag, "_busy"}, busy, 1'b1);
    lat       = 0;
    seen      = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        opA = $urandom;
        opB = $urandom;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!stall_req) stall_bad++;
    end
    check_eq({tag, "_seen"}, seen, 1'b1);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, result, exp);
    check_eq({tag, "_stall_dn"}, stall_req, 1'b0);
    check_eq({tag, "_stall_wait"}, stall_bad, 0);
    // start still high across the retiring edge must not retrigger
    @(posedge clk); #1;
    check_eq({tag, "_noretrig_busy"}, busy, 1'b0);
    check_eq({tag, "_noretrig_done"}, done, 1'b0);
    start = 1'b0;
    last_result = exp;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int extra_done;
    rstn = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; opA = '0; opB = '0;
    last_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_stall", stall_req, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_op("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD);
    check_eq("mul_neg_const", last_result, 32'hFFFF_FFEB);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 3'b101, 32'd100, 32'd7);
    run_op("remu", 3'b111, 32'd100, 32'd7);
    run_op("div0", 3'b100, 32'd5, 32'd0);
    run_op("remu0", 3'b111, 32'd5, 32'd0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in the middle of a divide.
    funct3 = 3'b101; opA = 32'd1000; opB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    check_eq("flush_busy", busy, 1'b0);
    check_eq("flush_done", done, 1'b0);
    check_eq("flush_result", result, last_result);
    check_eq("flush_stall", stall_req, 1'b0);
    flush = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_eq("flush_done2", done, 1'b0);
    check_eq("flush_busy2", busy, 1'b0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4);

    // Reset in the middle of a multiply.
    funct3 = 3'b000; opA = 32'd9; opB = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1;
    rstn = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_result", result, 32'h0);
    check_eq("midrst_stall", stall_req, 1'b0);
    rstn = 1'b1;
    extra_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check_eq("midrst_no_done", extra_done, 0);
    last_result = 32'h0;

    // Randomized instructions.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rand%0d_f%0d", n, f3), f3, a, b);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check_eq($sformatf("rand%0d_hold", n), result, last_result);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
